// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_if
// Brief    : Command/load/status bundle between a controller and the
//            hh:mm:ss countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
interface countdown_timer_if;
    logic       i_tick;
    logic       i_load;
    logic       i_start;
    logic       i_pause;
    logic [5:0] i_hh;
    logic [5:0] i_mm;
    logic [5:0] i_ss;
    logic [5:0] o_hh;
    logic [5:0] o_mm;
    logic [5:0] o_ss;
    logic       o_busy;
    logic       o_done;
    logic       o_alarm;

    modport master (
        output i_tick, i_load, i_start, i_pause, i_hh, i_mm, i_ss,
        input  o_hh, o_mm, o_ss, o_busy, o_done, o_alarm
    );

    modport slave (
        input  i_tick, i_load, i_start, i_pause, i_hh, i_mm, i_ss,
        output o_hh, o_mm, o_ss, o_busy, o_done, o_alarm
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : hh:mm:ss down-counter on a 1 Hz tick with done pulse and timed
//            alarm level after reaching 00:00:00.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int HH_MAX      = 23,
    parameter int ALARM_TICKS = 10
) (
    input  wire                 i_clk,
    input  wire                 i_rst,
    countdown_timer_if.slave    bus
);

    localparam logic [5:0] c_SS_MAX    = 6'd59;
    localparam logic [5:0] c_MM_MAX    = 6'd59;
    localparam logic [5:0] c_HH_MAX    = 6'(HH_MAX);
    localparam logic [5:0] c_ALARM_END = 6'(ALARM_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q;
    logic [5:0] hh_q, mm_q, ss_q;
    logic [5:0] acnt_q;
    logic       done_q;

    logic [5:0] hh_d, mm_d, ss_d;
    logic [5:0] hh_ld, mm_ld, ss_ld;
    logic       count_zero;
    logic       dec_zero;
    logic [5:0] acnt_inc;

    // One-second borrow chain; the zero case is never used because RUN
    // only decrements a nonzero count.
    always_comb begin
        hh_d = hh_q;
        mm_d = mm_q;
        ss_d = ss_q;
        if (ss_q != 6'd0) begin
            ss_d = ss_q - 6'd1;
        end else if (mm_q != 6'd0) begin
            ss_d = c_SS_MAX;
            mm_d = mm_q - 6'd1;
        end else if (hh_q != 6'd0) begin
            ss_d = c_SS_MAX;
            mm_d = c_MM_MAX;
            hh_d = hh_q - 6'd1;
        end
    end

    always_comb begin
        ss_ld = (bus.i_ss > c_SS_MAX) ? c_SS_MAX : bus.i_ss;
        mm_ld = (bus.i_mm > c_MM_MAX) ? c_MM_MAX : bus.i_mm;
        hh_ld = (bus.i_hh > c_HH_MAX) ? c_HH_MAX : bus.i_hh;
    end

    assign count_zero = (hh_q == 6'd0) && (mm_q == 6'd0) && (ss_q == 6'd0);
    assign dec_zero   = (hh_d == 6'd0) && (mm_d == 6'd0) && (ss_d == 6'd0);
    assign acnt_inc   = acnt_q + 6'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            hh_q    <= 6'd0;
            mm_q    <= 6'd0;
            ss_q    <= 6'd0;
            acnt_q  <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.i_load) begin
                hh_q    <= hh_ld;
                mm_q    <= mm_ld;
                ss_q    <= ss_ld;
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.i_start && !count_zero) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Start outranks pause; in RUN start is a no-op,
                        // so the tick still counts.
                        if (bus.i_pause && !bus.i_start) begin
                            state_q <= ST_PAUSE;
                        end else if (bus.i_tick && !count_zero) begin
                            hh_q <= hh_d;
                            mm_q <= mm_d;
                            ss_q <= ss_d;
                            if (dec_zero) begin
                                done_q  <= 1'b1;
                                acnt_q  <= 6'd0;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.i_start) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        if (bus.i_start && count_zero) begin
                            state_q <= ST_IDLE;
                        end else if (bus.i_tick) begin
                            acnt_q <= acnt_inc;
                            if (acnt_inc == c_ALARM_END) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_hh    = hh_q;
    assign bus.o_mm    = mm_q;
    assign bus.o_ss    = ss_q;
    assign bus.o_done  = done_q;
    assign bus.o_busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.o_alarm = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Directed self-checking bench for countdown_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    countdown_timer_if bus ();

    countdown_timer #(
        .HH_MAX      (23),
        .ALARM_TICKS (10)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Hold the given strobes across one rising edge, then sample 1 ns later.
    task automatic cyc(input logic t, input logic l, input logic s, input logic p);
        bus.i_tick  = t;
        bus.i_load  = l;
        bus.i_start = s;
        bus.i_pause = p;
        @(posedge clk);
        #1;
        bus.i_tick  = 1'b0;
        bus.i_load  = 1'b0;
        bus.i_start = 1'b0;
        bus.i_pause = 1'b0;
    endtask

    task automatic load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.i_hh = h;
        bus.i_mm = m;
        bus.i_ss = s;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hh"}, 32'(bus.o_hh), h);
        chk({tag, ".mm"}, 32'(bus.o_mm), m);
        chk({tag, ".ss"}, 32'(bus.o_ss), s);
    endtask

    task automatic chk_flags(input string tag, input logic b, input logic d, input logic a);
        chk({tag, ".busy"},  32'(bus.o_busy),  32'(b));
        chk({tag, ".done"},  32'(bus.o_done),  32'(d));
        chk({tag, ".alarm"}, 32'(bus.o_alarm), 32'(a));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        bus.i_tick = 1'b0; bus.i_load = 1'b0; bus.i_start = 1'b0; bus.i_pause = 1'b0;
        bus.i_hh = 6'd0; bus.i_mm = 6'd0; bus.i_ss = 6'd0;
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        chk_time("reset", 0, 0, 0);
        chk_flags("reset", 0, 0, 0);

        // 00:00:03 down to zero
        load(6'd0, 6'd0, 6'd3);
        chk_time("t1.load", 0, 0, 3);
        chk_flags("t1.load", 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk_flags("t1.start", 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t1.ss2", 32'(bus.o_ss), 2);
        cyc(1, 0, 0, 0);
        chk("t1.ss1", 32'(bus.o_ss), 1);
        cyc(1, 0, 0, 0);
        chk_time("t1.zero", 0, 0, 0);
        chk_flags("t1.zero", 0, 1, 1);
        cyc(0, 0, 0, 0);
        chk_flags("t1.after", 0, 0, 1);

        // alarm lasts exactly 10 ticks
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
        chk("t5.tick9.alarm", 32'(bus.o_alarm), 1);
        cyc(1, 0, 0, 0);
        chk_flags("t5.tick10", 0, 0, 0);
        chk_time("t5.tick10", 0, 0, 0);

        // load during DONE drops the alarm
        load(6'd0, 6'd0, 6'd1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("t5b.done", 32'(bus.o_done), 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk("t5b.tick4.alarm", 32'(bus.o_alarm), 1);
        load(6'd0, 6'd1, 6'd0);
        chk_flags("t5b.load", 0, 0, 0);
        chk_time("t5b.load", 0, 1, 0);

        // minute borrow, start with zero count exits DONE
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk_time("mm.borrow", 0, 0, 59);
        load(6'd0, 6'd0, 6'd1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("t5c.alarm", 32'(bus.o_alarm), 1);
        cyc(0, 0, 1, 0);
        chk_flags("t5c.start_exit", 0, 0, 0);

        // hour borrow and load clamping
        load(6'd1, 6'd0, 6'd0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk_time("t2.borrow", 0, 59, 59);
        load(6'd40, 6'd63, 6'd63);
        chk_time("t2.clamp", 23, 59, 59);
        chk("t2.clamp.busy", 32'(bus.o_busy), 0);

        // pause freezes the count, ticks ignored
        load(6'd0, 6'd0, 6'd10);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 1);
        chk("t3.pause.ss", 32'(bus.o_ss), 10);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        chk_time("t3.paused", 0, 0, 10);
        chk_flags("t3.paused", 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk_time("t3.resume", 0, 0, 9);

        // start with zero count stays idle
        load(6'd0, 6'd0, 6'd0);
        cyc(0, 0, 1, 0);
        chk_flags("t4.start0", 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_flags("t4.tick", 0, 0, 0);

        // reset mid-RUN with a tick
        load(6'd0, 6'd5, 6'd0);
        cyc(0, 0, 1, 0);
        rst = 1'b1;
        cyc(1, 0, 0, 0);
        rst = 1'b0;
        chk_time("t6.rst", 0, 0, 0);
        chk_flags("t6.rst", 0, 0, 0);

        // reset mid-DONE clears alarm and its counter
        load(6'd0, 6'd0, 6'd1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        chk_flags("t6.rst_done", 0, 0, 0);
        load(6'd0, 6'd0, 6'd1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
        chk("t6.acnt_cleared", 32'(bus.o_alarm), 1);
        cyc(1, 0, 0, 0);
        chk("t6.acnt_end", 32'(bus.o_alarm), 0);

        // load with a simultaneous tick
        load(6'd0, 6'd0, 6'd20);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("t6.run19", 32'(bus.o_ss), 19);
        bus.i_hh = 6'd0; bus.i_mm = 6'd0; bus.i_ss = 6'd30;
        cyc(1, 1, 0, 0);
        chk_time("t6.load_tick", 0, 0, 30);
        chk("t6.load_tick.busy", 32'(bus.o_busy), 0);
        cyc(1, 0, 0, 0);
        chk("t6.idle_tick", 32'(bus.o_ss), 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
